pwm_generator: RTL and testbench
================================

PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter: CNT_WIDTH, 8, width of the duty input and period counter; period = 2^CNT_WIDTH ticks.
REQ-002 Parameter: PRESCALE_WIDTH, 16, width of the prescale input.
REQ-003 Port: clk  input  1  single clock; all logic rising-edge clocked.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  1 = generate PWM; 0 = idle.
REQ-006 Port: duty  input  CNT_WIDTH  requested high count per period, driven by the 8-bit output register of the PIO peripheral upstream.
REQ-007 Port: prescale  input  PRESCALE_WIDTH  clk cycles per counter tick minus one.
REQ-008 Port: polarity  input  1  0 = active-high output; 1 = inverted output.
REQ-009 Port: pwm_out  output  1  registered PWM waveform.
REQ-010 Port: period_start  output  1  one-cycle pulse at the start of each period.
REQ-011 Port: duty_active  output  CNT_WIDTH  shadow duty value currently in effect.

Function
REQ-012 Prescaler counter (presc_cnt) SHALL increment each cycle while enable=1; a tick SHALL be asserted when presc_cnt >= prescale, and presc_cnt SHALL return to 0 in that same cycle.
REQ-013 prescale=0 SHALL produce a tick every clk cycle.
REQ-014 A prescale decrease below presc_cnt SHALL cause a tick on the next cycle, with no wrap through 2^PRESCALE_WIDTH.
REQ-015 Period counter (cnt) SHALL increment by 1 on each tick and wrap from 2^CNT_WIDTH-1 to 0.
REQ-016 duty_active SHALL load duty only on a tick at which cnt wraps to 0; mid-period duty changes SHALL have no effect until the next period.
REQ-017 While enable=0: presc_cnt=0, cnt=0, duty_active SHALL follow duty every cycle, and pwm_out SHALL equal polarity (inactive level).
REQ-018 The first period after enable rises SHALL use the duty value present on the last enable=0 cycle.
REQ-019 Raw waveform SHALL be (cnt < duty_active); pwm_out SHALL be registered as raw XOR polarity, one cycle after cnt changes.
REQ-020 duty=0 SHALL give a constant inactive level; duty=2^CNT_WIDTH-1 SHALL give active for 255 of 256 ticks.
REQ-021 period_start SHALL pulse for exactly one cycle, aligned with the pwm_out update for cnt=0, on every wrap and on the first tick after enable rises.
REQ-022 A polarity change SHALL take effect on pwm_out on the next cycle, with no period restart.
REQ-023 Deasserting enable mid-period SHALL force pwm_out inactive on the next cycle and abandon the period.

Reset
REQ-024 On reset=1 at a clk edge: presc_cnt=0, cnt=0, duty_active=0, pwm_out=0, period_start=0.
REQ-025 reset SHALL take priority over enable and all other inputs; a mid-period reset SHALL abandon the period.

Structure
REQ-026 Package pwm_pkg SHALL hold the CNT_WIDTH and PRESCALE_WIDTH defaults and the period-length constant.
REQ-027 The prescaler SHALL be a sub-module pwm_prescaler (inputs clk, reset, enable, prescale; output tick).
REQ-028 All outputs SHALL be driven from registers; there is no combinational path from input to output.

Verification
REQ-029 prescale=0, duty=64, polarity=0, enable=1 -> pwm_out high for 64 cycles and low for 192 cycles per 256-cycle period; period_start every 256 cycles.
REQ-030 prescale=3, duty=128 -> period of 1024 clk cycles, with pwm_out high for 512 of them.
REQ-031 duty changed from 64 to 200 at cnt=100 -> current period completes at 64; next period is high for 200 ticks; duty_active changes at the wrap.
REQ-032 duty=0 and duty=255, prescale=0 -> pwm_out constant 0, and 255 high / 1 low, respectively.
REQ-033 polarity=1, duty=64 -> pwm_out low for 64 and high for 192; enable=0 -> pwm_out=1.
REQ-034 reset asserted at cnt=150 with duty_active=200 -> next cycle: all state 0, pwm_out=0; after release with enable=1, the period restarts from cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and types for the PWM generator: counter widths,
// the period-length constant and the run/idle state encoding.
package pwm_pkg;

  localparam int CNT_WIDTH_DEF      = 8;
  localparam int PRESCALE_WIDTH_DEF = 16;
  localparam int PERIOD_LEN         = 1 << CNT_WIDTH_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick every (prescale + 1) clk cycles while enabled.
import pwm_pkg::*;

module pwm_prescaler #(
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] presc_cnt_reg;
  logic [PRESCALE_WIDTH-1:0] presc_cnt_next;

  // ">=" rather than "==" so that lowering prescale below the running count
  // fires on the next cycle instead of wrapping through the full range.
  always_comb begin
    tick           = enable && (presc_cnt_reg >= prescale);
    presc_cnt_next = presc_cnt_reg + PRESCALE_WIDTH'(1);
    if (!enable || tick) begin
      presc_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// PWM generator: prescaled period counter with shadowed duty, registered
// polarity-adjusted output and a period-start strobe aligned with it.
import pwm_pkg::*;

module pwm_generator #(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CNT_WIDTH-1:0]      duty,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      polarity,
  output logic                      pwm_out,
  output logic                      period_start,
  output logic [CNT_WIDTH-1:0]      duty_active
);

  logic tick;

  pwm_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  pwm_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] duty_active_reg, duty_active_next;
  logic                 start_reg, start_next;
  logic                 pwm_out_reg, pwm_out_next;
  logic                 period_start_reg, period_start_next;

  // start_reg marks the cycle in which cnt has just become 0; it is delayed
  // once more into period_start so the strobe lines up with pwm_out for cnt=0.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    duty_active_next  = duty_active_reg;
    start_next        = 1'b0;
    pwm_out_next      = polarity;
    period_start_next = start_reg;
    if (!enable) begin
      state_next        = ST_IDLE;
      cnt_next          = '0;
      duty_active_next  = duty;
      period_start_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (tick) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            start_next = 1'b1;
          end
        end
        ST_RUN: begin
          pwm_out_next = (cnt_reg < duty_active_reg) ^ polarity;
          if (tick) begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
            if (&cnt_reg) begin
              start_next       = 1'b1;
              duty_active_next = duty;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      duty_active_reg  <= '0;
      start_reg        <= 1'b0;
      pwm_out_reg      <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      duty_active_reg  <= duty_active_next;
      start_reg        <= start_next;
      pwm_out_reg      <= pwm_out_next;
      period_start_reg <= period_start_next;
    end
  end

  assign pwm_out      = pwm_out_reg;
  assign period_start = period_start_reg;
  assign duty_active  = duty_active_reg;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: expected period lengths, high counts
// and strobe latencies are queued before stimulus and compared on measurement.
import pwm_pkg::*;

module tb_pwm_generator;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [7:0]  duty;
  logic [15:0] prescale;
  logic        polarity;
  logic        pwm_out;
  logic        period_start;
  logic [7:0]  duty_active;

  pwm_generator #(
    .CNT_WIDTH      (8),
    .PRESCALE_WIDTH (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .duty         (duty),
    .prescale     (prescale),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_active  (duty_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  localparam int TIMEOUT = 5000;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int actual);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, actual, e.val);
    end
  endtask

  // Disable for two cycles (so duty_active picks up the new duty), then enable.
  task automatic restart(input int presc, input logic [7:0] d, input logic pol);
    enable   = 1'b0;
    prescale = presc[15:0];
    duty     = d;
    polarity = pol;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (!period_start && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called on a period_start sample; counts cycles and active samples up to
  // the next period_start, optionally rewriting duty after change_at cycles.
  task automatic measure(input int change_at, input logic [7:0] new_duty,
                         output int len, output int highs);
    len   = 0;
    highs = 0;
    do begin
      if (pwm_out) highs++;
      len++;
      if (len == change_at) duty = new_duty;
      @(negedge clk);
    end while (!period_start && len < TIMEOUT);
  endtask

  int lat, len, highs, n;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    duty     = 8'd0;
    prescale = 16'd0;
    polarity = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    sb_push("rst_pwm_out", 0);
    sb_push("rst_period_start", 0);
    sb_push("rst_duty_active", 0);
    sb_check(pwm_out);
    sb_check(period_start);
    sb_check(duty_active);

    // Idle: duty_active follows duty, pwm_out sits at the inactive level
    reset    = 1'b0;
    duty     = 8'd64;
    polarity = 1'b1;
    sb_push("idle_duty_follow", 64);
    sb_push("idle_pwm_inverted", 1);
    @(negedge clk);
    sb_check(duty_active);
    sb_check(pwm_out);
    polarity = 1'b0;
    sb_push("idle_pwm_normal", 0);
    @(negedge clk);
    sb_check(pwm_out);

    // 64/256 at prescale 0, two consecutive periods
    sb_push("p64_first_latency", 2);
    sb_push("p64_len_a", PERIOD_LEN);
    sb_push("p64_high_a", 64);
    sb_push("p64_len_b", PERIOD_LEN);
    sb_push("p64_high_b", 64);
    restart(0, 8'd64, 1'b0);
    wait_start(lat);
    sb_check(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);

    // prescale 3, duty 128: 1024-cycle period, 512 high
    sb_push("ps3_first_latency", 5);
    sb_push("ps3_len", 4 * PERIOD_LEN);
    sb_push("ps3_high", 512);
    restart(3, 8'd128, 1'b0);
    wait_start(lat);
    sb_check(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);

    // Mid-period duty change 64 -> 200 takes effect only at the wrap
    sb_push("dchg_len_cur", PERIOD_LEN);
    sb_push("dchg_high_cur", 64);
    sb_push("dchg_active_at_wrap", 200);
    sb_push("dchg_len_next", PERIOD_LEN);
    sb_push("dchg_high_next", 200);
    restart(0, 8'd64, 1'b0);
    wait_start(lat);
    measure(100, 8'd200, len, highs);
    sb_check(len);
    sb_check(highs);
    sb_check(duty_active);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);

    // Duty extremes
    sb_push("duty0_len", PERIOD_LEN);
    sb_push("duty0_high", 0);
    restart(0, 8'd0, 1'b0);
    wait_start(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);
    sb_push("duty255_len", PERIOD_LEN);
    sb_push("duty255_high", 255);
    restart(0, 8'd255, 1'b0);
    wait_start(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);

    // Inverted polarity: 192 of 256 samples high; disable forces 1
    sb_push("inv_len", PERIOD_LEN);
    sb_push("inv_high", 192);
    sb_push("inv_disable_pwm", 1);
    sb_push("inv_disable_start", 0);
    restart(0, 8'd64, 1'b1);
    wait_start(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);
    enable = 1'b0;
    @(negedge clk);
    sb_check(pwm_out);
    sb_check(period_start);

    // Polarity flip mid-period: output inverts next cycle, period not restarted
    sb_push("polflip_pwm", 0);
    sb_push("polflip_len", PERIOD_LEN);
    restart(0, 8'd64, 1'b0);
    wait_start(lat);
    repeat (10) @(negedge clk);
    polarity = 1'b1;
    @(negedge clk);
    sb_check(pwm_out);
    wait_start(lat);
    sb_check(11 + lat);

    // Enable dropped while active-high: inactive on the next cycle
    sb_push("endrop_pwm", 0);
    restart(0, 8'd64, 1'b0);
    wait_start(lat);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    sb_check(pwm_out);

    // Reset at cnt~150 with duty_active=200, then restart from cnt=0
    sb_push("midrst_pwm", 0);
    sb_push("midrst_start", 0);
    sb_push("midrst_duty_active", 0);
    sb_push("midrst_latency", 2);
    sb_push("midrst_len_a", PERIOD_LEN);
    sb_push("midrst_high_a", 0);
    sb_push("midrst_len_b", PERIOD_LEN);
    sb_push("midrst_high_b", 200);
    restart(0, 8'd200, 1'b0);
    wait_start(lat);
    for (n = 0; n < 149; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb_check(pwm_out);
    sb_check(period_start);
    sb_check(duty_active);
    reset = 1'b0;
    wait_start(lat);
    sb_check(lat);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);
    measure(0, 8'd0, len, highs);
    sb_check(len);
    sb_check(highs);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
